daq_sample_fifo: RTL and testbench

Multi-channel ADC sample buffer sitting between the LVDS ADC frame receivers and the AXI4-Lite register front-end of the DNCDAQ subsystem. Accepts tagged samples from up to CHANNELS converters, filters them by a channel mask, widens them to the bus word width, and stores them in a single power-of-two FIFO. Raises a level interrupt when the fill level reaches a programmable threshold so software can drain a fixed block per interrupt.

---
 rtl/daq_pkg.sv | 20 ++
 rtl/daq_sdp_ram.sv | 22 ++
 rtl/daq_sample_fifo.sv | 141 ++++++++++++++
 tb/tb_daq_sample_fifo.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/daq_pkg.sv
// Shared types and helpers for the DAQ sample path.
// The channel-tag word format is selected by the DAQ_FIFO_CH_TAG_EN macro in daq_sample_fifo.
package daq_pkg;

  // Sample words are carried at the widest supported width and sliced to OUT_W by users.
  localparam int unsigned MaxOutW = 64;
  localparam int unsigned ChTagW  = 4;

  typedef logic [MaxOutW-1:0] sample_word_t;

  function automatic sample_word_t sign_extend(input sample_word_t value, input int unsigned width);
    sample_word_t result;
    result = value;
    for (int unsigned i = 0; i < MaxOutW; i++) begin
      if (i >= width) result[i] = value[width-1];
    end
    return result;
  endfunction

endpackage

// File: rtl/daq_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset so it maps to block RAM.
module daq_sdp_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/daq_sample_fifo.sv
// Multi-channel ADC sample FIFO with channel mask, sticky error flags and threshold IRQ.
// Define DAQ_FIFO_CH_TAG_EN to store the channel index in the top 4 bits of each word.
module daq_sample_fifo
  import daq_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned ADC_W    = 24,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned DEPTH    = 1024
) (
  input  logic                                            aclk,
  input  logic                                            areset,
  input  logic                                            enable,
  input  logic [CHANNELS-1:0]                             ch_mask,
  input  logic                                            in_valid,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] in_ch,
  input  logic [ADC_W-1:0]                                in_data,
  input  logic                                            flush,
  input  logic                                            rd_en,
  output logic [OUT_W-1:0]                                rd_data,
  output logic                                            rd_valid,
  input  logic [$clog2(DEPTH+1)-1:0]                      threshold,
  input  logic                                            irq_en,
  output logic                                            irq,
  output logic [$clog2(DEPTH+1)-1:0]                      count,
  output logic                                            overflow,
  output logic                                            underflow,
  input  logic                                            clear_err
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned ChW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             rd_valid_q;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             irq_q, irq_d;

  logic             ch_ok;
  logic             wr_ok;
  logic             wr_accept;
  logic             rd_accept;
  logic             full;
  logic             empty;
  sample_word_t     ext;
  logic [OUT_W-1:0] wr_word;
  logic [OUT_W-1:0] ram_rdata;
  logic             unused_ext_hi;

  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);

  assign ch_ok     = (32'(in_ch) < CHANNELS) && ch_mask[in_ch];
  assign wr_ok     = in_valid && enable && ch_ok && !flush;
  assign wr_accept = wr_ok && !full;
  assign rd_accept = rd_en && !empty && !flush;

`ifdef DAQ_FIFO_CH_TAG_EN
  logic [ChTagW-1:0] tag;

  always_comb begin
    ext = sign_extend(sample_word_t'(in_data), ADC_W);
    tag = '0;
    tag[ChW-1:0] = in_ch;
    wr_word = {tag, ext[OUT_W-ChTagW-1:0]};
  end
`else
  always_comb begin
    ext = sign_extend(sample_word_t'(in_data), ADC_W);
    wr_word = ext[OUT_W-1:0];
  end
`endif

  assign unused_ext_hi = ^ext[MaxOutW-1:OUT_W];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (rd_accept) rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(wr_accept) - CntW'(rd_accept);
    end
    // A same-cycle error event beats clear_err.
    ovf_d = (wr_ok && full) || (ovf_q && !clear_err);
    udf_d = (rd_en && empty) || (udf_q && !clear_err);
    irq_d = irq_en && (threshold != '0) && (count_q >= threshold);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_accept;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      irq_q      <= irq_d;
    end
  end

  daq_sdp_ram #(
    .DEPTH (DEPTH),
    .WIDTH (OUT_W)
  ) u_ram (
    .clk   (aclk),
    .we    (wr_accept),
    .waddr (wr_ptr_q),
    .wdata (wr_word),
    .re    (rd_accept),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // RAM output has no reset; gating by rd_valid gives a clean zero after reset.
  assign rd_data   = rd_valid_q ? ram_rdata : '0;
  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_daq_sample_fifo.sv
// Scoreboard bench for daq_sample_fifo: stimulus queues expected words, a monitor checks pops.
module tb_daq_sample_fifo;

  logic        aclk = 1'b0;
  logic        areset;
  logic        enable;
  logic [3:0]  ch_mask;
  logic        in_valid;
  logic [1:0]  in_ch;
  logic [23:0] in_data;
  logic        flush;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [10:0] threshold;
  logic        irq_en;
  logic        irq;
  logic [10:0] count;
  logic        overflow;
  logic        underflow;
  logic        clear_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  daq_sample_fifo #(
    .CHANNELS (4),
    .ADC_W    (24),
    .OUT_W    (32),
    .DEPTH    (1024)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .enable    (enable),
    .ch_mask   (ch_mask),
    .in_valid  (in_valid),
    .in_ch     (in_ch),
    .in_data   (in_data),
    .flush     (flush),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .threshold (threshold),
    .irq_en    (irq_en),
    .irq       (irq),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow),
    .clear_err (clear_err)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [1:0] ch, input logic [23:0] d);
    logic [31:0] w;
    w = {{8{d[23]}}, d};
`ifdef DAQ_FIFO_CH_TAG_EN
    w[31:28] = {2'b00, ch};
`endif
    return w;
  endfunction

  always @(negedge aclk) begin
    if (!areset && rd_valid) begin
      if (exp_q.size() == 0) check("rd_valid_unexpected", rd_valid, 1'b0);
      else check("rd_data", rd_data, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [23:0] d, input bit accept);
    in_valid = 1'b1;
    in_ch    = ch;
    in_data  = d;
    if (accept) exp_q.push_back(model_word(ch, d));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic rd_n(input int n);
    rd_en = 1'b1;
    repeat (n) tick();
    rd_en = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    tick();
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1; enable = 1'b0; ch_mask = 4'hF; in_valid = 1'b0; in_ch = '0;
    in_data = '0; flush = 1'b0; rd_en = 1'b0; threshold = '0; irq_en = 1'b0;
    clear_err = 1'b0;
    repeat (3) tick();
    areset = 1'b0;
    @(negedge aclk);
    check("reset_count", count, 11'd0);
    check("reset_rd_valid", rd_valid, 1'b0);
    check("reset_rd_data", rd_data, 32'd0);
    check("reset_irq", irq, 1'b0);
    check("reset_overflow", overflow, 1'b0);
    check("reset_underflow", underflow, 1'b0);
    tick();

    // 300 samples on ch0 reaching the IRQ threshold
    enable = 1'b1; threshold = 11'd300; irq_en = 1'b1;
    for (int i = 0; i < 300; i++) wr(2'd0, 24'(i * 70001 + 5), 1'b1);
    @(negedge aclk);
    check("thr_count", count, 11'd300);
    check("thr_irq_early", irq, 1'b0);
    @(negedge aclk);
    check("thr_irq_rise", irq, 1'b1);
    tick();
    rd_n(300);
    wait_empty("thr_drain");
    tick();
    check("thr_count_empty", count, 11'd0);
    check("thr_irq_drop", irq, 1'b0);

    // Sign extension of a negative ch2 sample
    in_valid = 1'b1; in_ch = 2'd2; in_data = 24'h800001;
`ifdef DAQ_FIFO_CH_TAG_EN
    exp_q.push_back(32'h2F800001);
`else
    exp_q.push_back(32'hFF800001);
`endif
    tick();
    in_valid = 1'b0;
    rd_n(1);
    wait_empty("sign_ext");

    // Fill completely, then a write with a concurrent read must be dropped
    for (int i = 0; i < 1024; i++) wr(2'(i), 24'(i * 12345 + 1), 1'b1);
    @(negedge aclk);
    check("full_count", count, 11'd1024);
    tick();
    in_valid = 1'b1; in_ch = 2'd1; in_data = 24'h5A5A5A; rd_en = 1'b1;
    tick();
    in_valid = 1'b0; rd_en = 1'b0;
    @(negedge aclk);
    check("ovf_count", count, 11'd1023);
    check("ovf_flag", overflow, 1'b1);
    tick();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    @(negedge aclk);
    check("ovf_cleared", overflow, 1'b0);
    check("udf_clear_state", underflow, 1'b0);
    tick();
    rd_n(1023);
    wait_empty("full_drain");

    // Channel mask 0101 with round-robin channels
    ch_mask = 4'b0101;
    for (int i = 0; i < 400; i++) wr(2'(i), 24'(i * 977 + 3), ((i % 4) == 0) || ((i % 4) == 2));
    @(negedge aclk);
    check("mask_count", count, 11'd200);
    tick();
    rd_n(200);
    wait_empty("mask_drain");
    ch_mask = 4'hF;

    // Underflow, then flush against concurrent write and read
    rd_n(1);
    @(negedge aclk);
    check("udf_flag", underflow, 1'b1);
    check("udf_rd_valid", rd_valid, 1'b0);
    tick();
    for (int i = 0; i < 50; i++) wr(2'd3, 24'(i + 100), 1'b1);
    @(negedge aclk);
    check("flush_pre_count", count, 11'd50);
    tick();
    flush = 1'b1; in_valid = 1'b1; in_ch = 2'd0; in_data = 24'h000777; rd_en = 1'b1;
    exp_q.delete();
    tick();
    flush = 1'b0; in_valid = 1'b0; rd_en = 1'b0;
    @(negedge aclk);
    check("flush_count", count, 11'd0);
    check("flush_udf_kept", underflow, 1'b1);
    check("flush_rd_valid", rd_valid, 1'b0);
    tick();

    // Asynchronous reset with data, irq and a read in flight
    for (int i = 0; i < 500; i++) wr(2'(i), 24'(i * 31 + 7), 1'b1);
    tick();
    tick();
    @(negedge aclk);
    check("rst_pre_irq", irq, 1'b1);
    check("rst_pre_count", count, 11'd500);
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    #2;
    areset = 1'b1;
    exp_q.delete();
    #1;
    check("arst_count", count, 11'd0);
    check("arst_irq", irq, 1'b0);
    check("arst_rd_valid", rd_valid, 1'b0);
    check("arst_rd_data", rd_data, 32'd0);
    check("arst_overflow", overflow, 1'b0);
    check("arst_underflow", underflow, 1'b0);
    tick();
    areset = 1'b0;
    tick();
    wr(2'd1, 24'h123456, 1'b1);
    rd_n(1);
    wait_empty("post_reset_read");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
